// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
// Shared constants for the Hamming(21,16) encoder/decoder pair.
//   N, K, P        : code length, message length, number of parity bits
//   PARITY_POS     : 1-based code positions of the even-parity bits
//   DATA_POS       : 1-based code position of each message bit m[0..K-1]
//   MAX_POS        : largest syndrome that names a real code position
//   syn_mask(k)    : mask of code bits that contribute to syndrome bit k
// -----------------------------------------------------------------------------
package hamming_pkg;

   localparam int N = 21;
   localparam int K = 16;
   localparam int P = 5;

   localparam int PARITY_POS [P] = '{1, 2, 4, 8, 16};
   localparam int DATA_POS   [K] = '{3, 5, 6, 7, 9, 10, 11, 12,
                                     13, 14, 15, 17, 18, 19, 20, 21};

   localparam logic [P-1:0] MAX_POS = P'(N);

   // Bit i of the mask is set when code position i+1 has bit k set in its
   // index. Parity bit k sits at position 2**k, so it is in its own mask.
   function automatic logic [N-1:0] syn_mask(input int k);
      logic [N-1:0] mask;
      mask = '0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (((i + 1) >> k) & 1) == 1;
      end
      return mask;
   endfunction

endpackage

// File: rtl/hamming_decoder_pipe_if.sv
// -----------------------------------------------------------------------------
// hamming_decoder_pipe_if
// Valid/ready stream bundle around the decoder.
//   e, in_valid / in_ready            : received codeword in
//   m, err_*, out_valid / out_ready   : decoded word and status out
// Modports:
//   master : the environment (drives codewords, consumes results)
//   slave  : the decoder
// -----------------------------------------------------------------------------
interface hamming_decoder_pipe_if;
   import hamming_pkg::*;

   logic [N-1:0] e;
   logic         in_valid;
   logic         in_ready;
   logic [K-1:0] m;
   logic         out_valid;
   logic         out_ready;
   logic         err_corr;
   logic         err_unc;
   logic [P-1:0] err_pos;

   modport master (
      output e, in_valid, out_ready,
      input  in_ready, m, out_valid, err_corr, err_unc, err_pos
   );

   modport slave (
      input  e, in_valid, out_ready,
      output in_ready, m, out_valid, err_corr, err_unc, err_pos
   );

endinterface

// File: rtl/hamming_syndrome.sv
// -----------------------------------------------------------------------------
// hamming_syndrome
// Purely combinational syndrome calculator for the Hamming(21,16) code.
//   e        : 21-bit received codeword, e[i] is code position i+1
//   syndrome : 5-bit syndrome; 0 = clean, 1..21 = position in error,
//              22..31 = not a valid position
// -----------------------------------------------------------------------------
module hamming_syndrome
   import hamming_pkg::*;
(
   input  logic [N-1:0] e,
   output logic [P-1:0] syndrome
);

   for (genvar gi = 0; gi < P; gi++) begin : g_syn
      localparam logic [N-1:0] MASK = syn_mask(gi);
      assign syndrome[gi] = ^(e & MASK);
   end

endmodule

// File: rtl/hamming_decoder_pipe.sv
// -----------------------------------------------------------------------------
// hamming_decoder_pipe
// Two-stage pipelined Hamming(21,16) single-error-correcting decoder with
// valid/ready flow control and saturating error counters.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : codeword in / decoded word + flags out (slave side)
//   cnt_clr   : synchronous clear of both counters (wins over increment)
//   cnt_corr  : delivered words that had a corrected single-bit error
//   cnt_unc   : delivered words flagged uncorrectable
// Stage 1 holds the codeword and its syndrome; stage 2 holds the corrected
// message and flags, and is the output register.
// -----------------------------------------------------------------------------
module hamming_decoder_pipe
   import hamming_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   hamming_decoder_pipe_if.slave bus,
   input  logic                  cnt_clr,
   output logic [CNT_W-1:0]      cnt_corr,
   output logic [CNT_W-1:0]      cnt_unc
);

   // stage 1
   logic             s1_valid_q, s1_valid_d;
   logic [N-1:0]     s1_code_q,  s1_code_d;
   logic [P-1:0]     s1_syn_q,   s1_syn_d;
   // stage 2 / output
   logic             out_valid_q, out_valid_d;
   logic [K-1:0]     m_q,         m_d;
   logic             corr_q,      corr_d;
   logic             unc_q,       unc_d;
   logic [P-1:0]     pos_q,       pos_d;
   // counters
   logic [CNT_W-1:0] cnt_corr_q,  cnt_corr_d;
   logic [CNT_W-1:0] cnt_unc_q,   cnt_unc_d;

   logic [P-1:0]     syn;
   logic [N-1:0]     flip_mask;
   logic [N-1:0]     code_fixed;
   logic [K-1:0]     data_fixed;
   logic             syn_corr;
   logic             syn_unc;
   logic             s2_adv;
   logic             out_fire;

   hamming_syndrome u_syn (
      .e        (bus.e),
      .syndrome (syn)
   );

   // One-hot flip at the position named by the syndrome. Syndromes 0 and
   // 22..31 match no position, so the word passes through untouched.
   for (genvar gi = 0; gi < N; gi++) begin : g_flip
      assign flip_mask[gi] = (s1_syn_q == P'(gi + 1));
   end

   assign code_fixed = s1_code_q ^ flip_mask;

   for (genvar gi = 0; gi < K; gi++) begin : g_extract
      assign data_fixed[gi] = code_fixed[DATA_POS[gi] - 1];
   end

   assign syn_corr = (s1_syn_q != '0) && (s1_syn_q <= MAX_POS);
   assign syn_unc  = (s1_syn_q > MAX_POS);

   // Stage 2 may load when empty or when its word is being taken now;
   // stage 1 then follows the same rule through s2_adv.
   assign s2_adv       = !out_valid_q || bus.out_ready;
   assign out_fire     = out_valid_q && bus.out_ready;
   assign bus.in_ready = !s1_valid_q || s2_adv;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_code_d   = s1_code_q;
      s1_syn_d    = s1_syn_q;
      out_valid_d = out_valid_q;
      m_d         = m_q;
      corr_d      = corr_q;
      unc_d       = unc_q;
      pos_d       = pos_q;
      cnt_corr_d  = cnt_corr_q;
      cnt_unc_d   = cnt_unc_q;

      if (bus.in_ready) begin
         s1_valid_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_code_d = bus.e;
            s1_syn_d  = syn;
         end
      end

      // Output fields only change when a new word lands, so they hold
      // steady while the consumer stalls.
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            m_d    = data_fixed;
            corr_d = syn_corr;
            unc_d  = syn_unc;
            pos_d  = syn_corr ? s1_syn_q : '0;
         end
      end

      if (out_fire && corr_q && (cnt_corr_q != '1)) begin
         cnt_corr_d = cnt_corr_q + CNT_W'(1);
      end
      if (out_fire && unc_q && (cnt_unc_q != '1)) begin
         cnt_unc_d = cnt_unc_q + CNT_W'(1);
      end
      if (cnt_clr) begin
         cnt_corr_d = '0;
         cnt_unc_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_code_q   <= '0;
         s1_syn_q    <= '0;
         out_valid_q <= 1'b0;
         m_q         <= '0;
         corr_q      <= 1'b0;
         unc_q       <= 1'b0;
         pos_q       <= '0;
         cnt_corr_q  <= '0;
         cnt_unc_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_code_q   <= s1_code_d;
         s1_syn_q    <= s1_syn_d;
         out_valid_q <= out_valid_d;
         m_q         <= m_d;
         corr_q      <= corr_d;
         unc_q       <= unc_d;
         pos_q       <= pos_d;
         cnt_corr_q  <= cnt_corr_d;
         cnt_unc_q   <= cnt_unc_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.m         = m_q;
   assign bus.err_corr  = corr_q;
   assign bus.err_unc   = unc_q;
   assign bus.err_pos   = pos_q;
   assign cnt_corr      = cnt_corr_q;
   assign cnt_unc       = cnt_unc_q;

endmodule

// File: tb/tb_hamming_decoder_pipe.sv
// -----------------------------------------------------------------------------
// tb_hamming_decoder_pipe
// Directed, table-driven bench for hamming_decoder_pipe. One instance with
// 16-bit counters for the decode/stream/reset checks, one with 2-bit
// counters for saturation and clear priority. Inputs are driven and outputs
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_hamming_decoder_pipe;

   typedef struct {
      logic [20:0] e;
      logic [15:0] m;
      logic        corr;
      logic        unc;
      logic [4:0]  pos;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cnt_clr;
   logic [15:0] cnt_corr;
   logic [15:0] cnt_unc;
   logic        cnt_clr2;
   logic [1:0]  cnt_corr2;
   logic [1:0]  cnt_unc2;

   int   tests = 0;
   int   fails = 0;
   int   exp_corr = 0;
   int   exp_unc = 0;
   vec_t vecs [10];
   vec_t strm [32];

   hamming_decoder_pipe_if bus ();
   hamming_decoder_pipe_if bus2 ();

   hamming_decoder_pipe #(.CNT_W(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .cnt_clr  (cnt_clr),
      .cnt_corr (cnt_corr),
      .cnt_unc  (cnt_unc)
   );

   hamming_decoder_pipe #(.CNT_W(2)) dut_sat (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus2),
      .cnt_clr  (cnt_clr2),
      .cnt_corr (cnt_corr2),
      .cnt_unc  (cnt_unc2)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Streams strm[0..n-1] through the main DUT, optionally with random
   // out_ready stalls, checking order, content and hold-while-stalled.
   task automatic run_stream(input string tag, input int n, input bit rand_ready);
      int          tx = 0;
      int          rx = 0;
      int          cyc = 0;
      logic        prev_stall = 1'b0;
      logic [15:0] pm = '0;
      logic        pc = 1'b0;
      logic        pu = 1'b0;
      logic [4:0]  pp = '0;
      logic        in_fire;
      logic        out_fire;
      while ((tx < n || rx < n) && cyc < 400) begin
         @(negedge clk);
         bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (tx < n) begin
            bus.e        = strm[tx].e;
            bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         if (prev_stall) begin
            chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'(1));
            chk({tag, "_hold_m"},     32'(bus.m),         32'(pm));
            chk({tag, "_hold_corr"},  32'(bus.err_corr),  32'(pc));
            chk({tag, "_hold_unc"},   32'(bus.err_unc),   32'(pu));
            chk({tag, "_hold_pos"},   32'(bus.err_pos),   32'(pp));
         end
         in_fire  = bus.in_valid && bus.in_ready;
         out_fire = bus.out_valid && bus.out_ready;
         if (out_fire) begin
            if (rx < n) begin
               chk({tag, "_m"},    32'(bus.m),        32'(strm[rx].m));
               chk({tag, "_corr"}, 32'(bus.err_corr), 32'(strm[rx].corr));
               chk({tag, "_unc"},  32'(bus.err_unc),  32'(strm[rx].unc));
               chk({tag, "_pos"},  32'(bus.err_pos),  32'(strm[rx].pos));
               if (strm[rx].corr) exp_corr++;
               if (strm[rx].unc)  exp_unc++;
               $display("[TB] %s word %0d: m=%h corr=%0d unc=%0d pos=%0d", tag, rx,
                        bus.m, bus.err_corr, bus.err_unc, bus.err_pos);
            end else begin
               chk({tag, "_extra_word"}, 32'(rx), 32'(n - 1));
            end
            rx++;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         pm = bus.m;
         pc = bus.err_corr;
         pu = bus.err_unc;
         pp = bus.err_pos;
         if (in_fire) tx++;
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk({tag, "_delivered"}, 32'(rx), 32'(n));
      repeat (3) @(negedge clk);
      chk({tag, "_no_dup"},   32'(bus.out_valid), 32'(0));
      chk({tag, "_cnt_corr"}, 32'(cnt_corr),      32'(exp_corr));
      chk({tag, "_cnt_unc"},  32'(cnt_unc),       32'(exp_unc));
   endtask

   // One corrected word through the 2-bit-counter instance; optionally
   // raises cnt_clr in the very cycle of its output handshake.
   task automatic send_sat(input logic clr, input logic [1:0] exp_cnt);
      @(negedge clk);
      bus2.e        = 21'h000010;
      bus2.in_valid = 1'b1;
      @(negedge clk);
      bus2.in_valid = 1'b0;
      @(negedge clk);
      chk("sat_out_valid", 32'(bus2.out_valid), 32'(1));
      cnt_clr2 = clr;
      @(negedge clk);
      cnt_clr2 = 1'b0;
      chk("sat_cnt_corr", 32'(cnt_corr2), 32'(exp_cnt));
      $display("[TB] sat word clr=%0d cnt_corr=%0d", clr, cnt_corr2);
   endtask

   initial begin
      logic seen;

      //            e            m         corr  unc   pos
      vecs[0] = '{21'h000000, 16'h0000, 1'b0, 1'b0, 5'd0};
      vecs[1] = '{21'h000010, 16'h0000, 1'b1, 1'b0, 5'd5};
      vecs[2] = '{21'h008080, 16'h0000, 1'b0, 1'b1, 5'd0};
      vecs[3] = '{21'h0A786C, 16'h578D, 1'b0, 1'b0, 5'd0};
      vecs[4] = '{21'h000004, 16'h0000, 1'b1, 1'b0, 5'd3};
      vecs[5] = '{21'h000001, 16'h0000, 1'b1, 1'b0, 5'd1};
      vecs[6] = '{21'h100000, 16'h0000, 1'b1, 1'b0, 5'd21};
      vecs[7] = '{21'h008084, 16'h0001, 1'b0, 1'b1, 5'd0};
      vecs[8] = '{21'h0AF8EC, 16'h578D, 1'b0, 1'b1, 5'd0};
      vecs[9] = '{21'h1A786C, 16'h578D, 1'b1, 1'b0, 5'd21};

      rst           = 1'b1;
      cnt_clr       = 1'b0;
      cnt_clr2      = 1'b0;
      bus.e         = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus2.e        = '0;
      bus2.in_valid = 1'b0;
      bus2.out_ready = 1'b1;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
      chk("rst_in_ready",  32'(bus.in_ready),  32'(1));
      chk("rst_m",         32'(bus.m),         32'(0));
      chk("rst_flags",     32'({bus.err_corr, bus.err_unc, bus.err_pos}), 32'(0));
      chk("rst_cnt",       32'({cnt_corr, cnt_unc}), 32'(0));
      rst = 1'b0;

      // single words: latency, decode and counters
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.e        = vecs[i].e;
         bus.in_valid = 1'b1;
         #1;
         chk("vec_in_ready", 32'(bus.in_ready), 32'(1));
         @(negedge clk);
         bus.in_valid = 1'b0;
         chk("vec_lat_early", 32'(bus.out_valid), 32'(0));
         @(negedge clk);
         chk("vec_out_valid", 32'(bus.out_valid), 32'(1));
         chk("vec_m",         32'(bus.m),         32'(vecs[i].m));
         chk("vec_corr",      32'(bus.err_corr),  32'(vecs[i].corr));
         chk("vec_unc",       32'(bus.err_unc),   32'(vecs[i].unc));
         chk("vec_pos",       32'(bus.err_pos),   32'(vecs[i].pos));
         $display("[TB] vec %0d e=%h: m=%h corr=%0d unc=%0d pos=%0d", i, vecs[i].e,
                  bus.m, bus.err_corr, bus.err_unc, bus.err_pos);
         if (vecs[i].corr) exp_corr++;
         if (vecs[i].unc)  exp_unc++;
         @(negedge clk);
         chk("vec_drained",  32'(bus.out_valid), 32'(0));
         chk("vec_cnt_corr", 32'(cnt_corr),      32'(exp_corr));
         chk("vec_cnt_unc",  32'(cnt_unc),       32'(exp_unc));
      end

      // back-to-back 8 words with random stalls
      for (int i = 0; i < 8; i++) strm[i] = vecs[i];
      run_stream("stall", 8, 1'b1);

      // every single-position flip of the encoded 16'h578D, full rate
      for (int p = 1; p <= 21; p++) begin
         strm[p-1] = '{21'h0A786C ^ (21'd1 << (p - 1)), 16'h578D, 1'b1, 1'b0, 5'(p)};
      end
      run_stream("flip", 21, 1'b0);

      // saturation at 2 bits, then clear wins over a simultaneous increment
      send_sat(1'b0, 2'd1);
      send_sat(1'b0, 2'd2);
      send_sat(1'b0, 2'd3);
      send_sat(1'b0, 2'd3);
      send_sat(1'b0, 2'd3);
      send_sat(1'b1, 2'd0);
      chk("sat_cnt_unc", 32'(cnt_unc2), 32'(0));

      // reset with two words in flight
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.e         = 21'h000010;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      bus.e         = 21'h000004;
      @(negedge clk);
      bus.in_valid  = 1'b0;
      chk("mid_out_valid", 32'(bus.out_valid), 32'(1));
      chk("mid_in_ready",  32'(bus.in_ready),  32'(0));
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'(0));
      chk("mid_rst_in_ready",  32'(bus.in_ready),  32'(1));
      chk("mid_rst_m_pos",     32'({bus.m, bus.err_pos}), 32'(0));
      chk("mid_rst_cnt_corr",  32'(cnt_corr), 32'(0));
      chk("mid_rst_cnt_unc",   32'(cnt_unc),  32'(0));
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      chk("mid_no_output", 32'(seen), 32'(0));
      $display("[TB] mid-stream reset: out_valid seen=%0d", seen);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
